// File: rtl/inv_addkey_mixcol.sv
// inv_addkey_mixcol
//   AES decryption round stage downstream of the inverse S-box stage. An accepted
//   128-bit state is XORed with the round key (AddRoundKey). For non-final rounds
//   InvMixColumns is then applied one 32-bit column per cycle before the result
//   is presented.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    state_in / round_key / last_round are valid
//   in_ready    block can accept an input (IDLE only)
//   state_in    128-bit state, byte 0 at [127:120], column-major
//   round_key   128-bit round key, same byte order
//   last_round  1 = AddRoundKey only
//   out_valid   state_out holds a finished result (DONE only)
//   out_ready   consumer accepts state_out
//   state_out   128-bit result, column c at [127-32c : 96-32c]
module inv_addkey_mixcol (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last_round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMix  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] buf_q, buf_d;
    logic [31:0]  col_word;
    logic [31:0]  col_mixed;

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Constant multiplies built from the x, x^2, x^3 chain.
    function automatic logic [7:0] mul09(input logic [7:0] a);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ a;
    endfunction

    function automatic logic [7:0] mul0b(input logic [7:0] a);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ a;
    endfunction

    function automatic logic [7:0] mul0d(input logic [7:0] a);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ a;
    endfunction

    function automatic logic [7:0] mul0e(input logic [7:0] a);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        b0 = mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3);
        b1 = mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3);
        b2 = mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3);
        b3 = mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3);
        return {b0, b1, b2, b3};
    endfunction

    // Column currently being transformed.
    always_comb begin
        col_word = 32'h0;
        unique case (col_q)
            2'd0: col_word = buf_q[127:96];
            2'd1: col_word = buf_q[95:64];
            2'd2: col_word = buf_q[63:32];
            2'd3: col_word = buf_q[31:0];
            default: col_word = 32'h0;
        endcase
    end

    assign col_mixed = inv_mix_column(col_word);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        buf_d   = buf_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    buf_d   = state_in ^ round_key;
                    col_d   = 2'd0;
                    state_d = last_round ? StDone : StMix;
                end
            end
            StMix: begin
                unique case (col_q)
                    2'd0: buf_d[127:96] = col_mixed;
                    2'd1: buf_d[95:64]  = col_mixed;
                    2'd2: buf_d[63:32]  = col_mixed;
                    2'd3: buf_d[31:0]   = col_mixed;
                    default: buf_d = buf_q;
                endcase
                // 2-bit counter wraps to 0 on the last column.
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            col_q   <= 2'd0;
            buf_q   <= 128'h0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            buf_q   <= buf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign state_out = buf_q;

endmodule

// File: tb/tb_inv_addkey_mixcol.sv
module tb_inv_addkey_mixcol;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] state_in = '0;
    logic [127:0] round_key = '0;
    logic         last_round = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] state_out;

    int vectors = 0;
    int miscompares = 0;
    logic [127:0] exp_q[$];

    inv_addkey_mixcol dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .state_in   (state_in),
        .round_key  (round_key),
        .last_round (last_round),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .state_out  (state_out)
    );

    always #5 clk = ~clk;

    // Reference model: GF(2^8) shift-and-add multiply, matrix form of InvMixColumns.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int p = 0;
        int aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa << 1;
            if ((aa & 'h100) != 0) aa = aa ^ 'h11b;
        end
        return p[7:0];
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k,
                                           input logic last);
        logic [7:0]   coef[4];
        logic [7:0]   a[4];
        logic [7:0]   r;
        logic [127:0] t;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        t = s ^ k;
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                for (int j = 0; j < 4; j++) a[j] = t[127 - 32*c - 8*j -: 8];
                for (int row = 0; row < 4; row++) begin
                    r = 8'h00;
                    for (int j = 0; j < 4; j++) r = r ^ gmul(coef[(j - row + 4) % 4], a[j]);
                    t[127 - 32*c - 8*row -: 8] = r;
                end
            end
        end
        return t;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: a handshake seen at the falling edge completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_output: got %h expected none", state_out);
            end else begin
                check("result", state_out, exp_q.pop_front());
            end
        end
    end

    // Issue one block; optionally push its expectation and check accept-to-valid latency.
    // After the accept, inputs are scrambled to show they are not re-sampled.
    task automatic send(input logic [127:0] s, input logic [127:0] k, input logic last,
                        input bit push, input bit chk_lat);
        int waited = 0;
        int lat = 0;
        in_valid = 1'b1;
        state_in = s;
        round_key = k;
        last_round = last;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 100) begin
                check("accept_timeout", 128'(waited), 128'(0));
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        if (push) exp_q.push_back(model(s, k, last));
        #1;
        in_valid = 1'b0;
        state_in = {$urandom, $urandom, $urandom, $urandom};
        round_key = {$urandom, $urandom, $urandom, $urandom};
        last_round = 1'($urandom);
        if (chk_lat) begin
            while (!out_valid && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
                state_in = {$urandom, $urandom, $urandom, $urandom};
                round_key = {$urandom, $urandom, $urandom, $urandom};
            end
            check(last ? "latency_last" : "latency_mix", 128'(lat), last ? 128'(0) : 128'(4));
        end
    endtask

    initial begin : stim
        logic [127:0] hold_val;
        int drain = 0;

        #2;
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_state_out", state_out, 128'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed vectors.
        send(128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, 128'h0, 1'b0, 1'b1, 1'b1);
        check("dir_zero_key", model(128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, 128'h0, 1'b0),
              128'hdb135345_f20a225c_01010101_d4d4d4d5);
        send(128'h71b25e43_6023a762_fefefefe_2a2a2829, {128{1'b1}}, 1'b0, 1'b1, 1'b1);
        send(128'hea835cf0_0445332d_655d98ad_8596b0c5,
             128'hffffffff_00000000_ffffffff_00000000, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        check("dir_last_state_out", state_out, 128'h157ca30f_0445332d_9aa26752_8596b0c5);

        // Reset in the middle of MIX: outputs return to defaults without a clock edge.
        send(128'h0123456789abcdef_fedcba9876543210, 128'h5a5a, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 128'(in_ready), 128'(1));
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        check("midrst_state_out", state_out, 128'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, 128'h0, 1'b0, 1'b1, 1'b1);

        // Backpressure with a second block pending.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(128'hdeadbeef_cafef00d_01234567_89abcdef, 128'h1111_2222, 1'b0, 1'b1, 1'b1);
        hold_val = model(128'hdeadbeef_cafef00d_01234567_89abcdef, 128'h1111_2222, 1'b0);
        in_valid = 1'b1;
        state_in = 128'h00112233_44556677_8899aabb_ccddeeff;
        round_key = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
        last_round = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_state_out", state_out, hold_val);
            check("bp_in_ready", 128'(in_ready), 128'(0));
            check("bp_out_valid", 128'(out_valid), 128'(1));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        #1;
        check("hs_cycle_in_ready", 128'(in_ready), 128'(0));
        send(128'h00112233_44556677_8899aabb_ccddeeff,
             128'h0f0e0d0c_0b0a0908_07060504_03020100, 1'b0, 1'b1, 1'b1);

        // Randomized blocks.
        for (int n = 0; n < 24; n++) begin
            send({$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom}, 1'($urandom), 1'b1, 1'b1);
        end

        while (exp_q.size() != 0 && drain < 50) begin
            @(posedge clk);
            drain++;
        end
        check("queue_drained", 128'(exp_q.size()), 128'(0));
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
